mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the data-memory interface. Accepts one load/store request
//  from the core (valid/ready) and drives word-wide data-memory ports
//  (async read, sync write). Handles byte/halfword lane select, sign/zero
//  extension, and read-modify-write for sub-word stores.
//  Reports misaligned, illegal-funct3 and out-of-range accesses instead of
//  touching memory. Sits between the execute stage and data_memory.
// PARAMETERS
//  ADDR_LIMIT   65536  byte size of backing memory; byte addr >= ADDR_LIMIT -> access fault
// PORTS
//  clk            in   1   single clock, all state on posedge
//  reset          in   1   synchronous, active-high
//  req_valid      in   1   request present
//  req_ready      out  1   unit idle, can accept request
//  req_write      in   1   1=store, 0=load
//  req_funct3     in   3   RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data; low byte/half used for SB/SH
//  resp_valid     out  1   response held until resp_ready
//  resp_ready     in   1   consumer accepts response
//  resp_rdata     out  32  load result, extended; 0 for stores and errors
//  resp_error     out  2   00 ok, 01 misaligned, 10 illegal funct3, 11 access fault
//  mem_addr       out  32  {addr[31:2],2'b00} while mem_read|mem_write, else 0
//  mem_din        out  32  write data while mem_write, else 0
//  mem_read       out  1   read strobe; mem_dout sampled in the same cycle
//  mem_write      out  1   write strobe, one cycle per write
//  mem_dout       in   32  memory read data, combinational from mem_addr
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_error=00;
//   mem_read=mem_write=0, mem_addr=mem_din=0. Reset mid-operation aborts;
//   a pending RMW write is never issued.
//  Handshake: accept when req_valid & req_ready (IDLE only); latch funct3,
//   addr, wdata, write. req_ready=0 from the cycle after accept until back in IDLE.
//  Checks on accept, priority: illegal funct3 (011,110,111; store with 1xx)
//   -> 10; misaligned (H/HU addr[0]!=0, W addr[1:0]!=0) -> 01;
//   addr >= ADDR_LIMIT -> 11. Any error: go RESP directly, no memory strobe.
//  FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
//   IDLE   -accept, error->RESP; load->LOAD; SW->STORE; SB/SH->RMW_RD
//   LOAD   mem_read=1; extract lane, extend, register into resp_rdata; ->RESP
//   STORE  mem_write=1, mem_din=wdata; ->RESP
//   RMW_RD mem_read=1; register mem_dout as old word; ->RMW_WR
//   RMW_WR mem_write=1, mem_din=old word with target lane(s) replaced; ->RESP
//   RESP   resp_valid=1; stay until resp_ready; then ->IDLE with outputs cleared
//  Latency, accept at cycle T, resp_ready tied high:
//   load/SW resp_valid at T+2; SB/SH at T+3; error at T+1.
//  Lanes little-endian: byte k = bits [8k+7:8k], half at addr[1]*16.
//   LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
//  At most one mem strobe per cycle; mem_read and mem_write never both high.
//  resp_rdata and resp_error are stable while resp_valid is high and
//   resp_ready is low. New request accepted no earlier than the cycle after
//   the RESP handshake.
// STRUCTURE
//  mem_access_pkg: funct3 constants, state encoding, resp_error codes.
//  Sub-module mem_lane_align (combinational): load extract/extend and
//   store merge from funct3, addr[1:0], word, wdata. FSM and registers
//   stay in mem_access_unit.
// TESTING
//  SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_write at T+1, resp at T+2, rdata 0xDEADBEEF.
//  Word 0x8070F0AA at 0x20: LB 0x20->0xFFFFFFAA; LBU 0x20->0x000000AA; LH 0x22->0xFFFF8070; LHU 0x22->0x00008070.
//  SB 0x21 data 0x55 over 0x11223344 -> read T+1, write 0x11225544 at T+2, resp T+3.
//  LW 0x13 -> error 01 at T+1; LH 0x5 -> 01; funct3 011 -> 10; SW 0x10000 -> 11; no mem strobes.
//  resp_ready held low 4 cycles -> resp_valid, rdata, error stable; req_ready=0 throughout.
//  reset asserted in RMW_RD of SH -> no mem_write; next cycle IDLE, req_ready=1.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory access unit: width codes, FSM states,
// response error codes and the request legality check.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_FUNCT3   = 2'b10,
    ERR_FAULT    = 2'b11
  } err_e;

  // Illegal width beats misalignment, which beats an out-of-range address.
  function automatic err_e check_req(input logic        wr,
                                     input logic [2:0]  f3,
                                     input logic [31:0] addr,
                                     input logic [31:0] limit);
    logic illegal;
    logic misaligned;
    illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (wr && f3[2]);
    misaligned = ((f3[1:0] == 2'b01) && addr[0]) ||
                 ((f3 == F3_W) && (addr[1:0] != 2'b00));
    if (illegal)             return ERR_FUNCT3;
    else if (misaligned)     return ERR_MISALIGN;
    else if (addr >= limit)  return ERR_FAULT;
    else                     return ERR_OK;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges sub-word store data into the previously read word.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_o = {24'd0, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_o = {16'd0, half_sel};
      default: load_o = word_i;
    endcase
  end

  // Sub-word stores keep the untouched lanes of the old word.
  always_comb begin
    store_o = word_i;
    case (funct3_i[1:0])
      2'b00:   store_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
      2'b01:   store_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: store_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between execute and data memory: one request at a time,
// lane select/extension, read-modify-write for SB/SH, error reporting.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  localparam logic [31:0] LIMIT = 32'(ADDR_LIMIT);

  state_e      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] old_q, old_d;
  logic [31:0] rdata_q, rdata_d;
  err_e        err_q, err_d;
  err_e        chk_err;

  logic [31:0] align_word;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign chk_err    = check_req(req_write, req_funct3, req_addr, LIMIT);
  assign align_word = (state_q == S_RMW_WR) ? old_q : mem_dout;

  mem_lane_align u_align (
    .funct3_i (funct3_q),
    .lane_i   (addr_q[1:0]),
    .word_i   (align_word),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .store_o  (store_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      old_q    <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= ERR_OK;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      old_q    <= old_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    old_d    = old_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = 32'd0;
          err_d    = chk_err;
          if (chk_err != ERR_OK)       state_d = S_RESP;
          else if (!req_write)         state_d = S_LOAD;
          else if (req_funct3 == F3_W) state_d = S_STORE;
          else                         state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        rdata_d = load_data;
        state_d = S_RESP;
      end
      S_STORE:  state_d = S_RESP;
      S_RMW_RD: begin
        old_d   = mem_dout;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: state_d = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          rdata_d = 32'd0;
          err_d   = ERR_OK;
          state_d = S_IDLE;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_rdata = rdata_q;
    resp_error = err_q;
    mem_read   = (state_q == S_LOAD) || (state_q == S_RMW_RD);
    mem_write  = (state_q == S_STORE) || (state_q == S_RMW_WR);
    mem_addr   = 32'd0;
    mem_din    = 32'd0;
    if (mem_read || mem_write) mem_addr = {addr_q[31:2], 2'b00};
    if (state_q == S_STORE)    mem_din  = wdata_q;
    if (state_q == S_RMW_WR)   mem_din  = store_word;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_error;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_read, mem_write;

  logic [31:0] mem [0:63];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_din;

  mem_access_unit #(.ADDR_LIMIT(65536)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_dout   (mem_dout)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
    int          strobes;
    int          wlat;
    logic [31:0] wdat;
  } vec_t;

  vec_t vt [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
  endtask

  task automatic do_req(input vec_t v, input int idx);
    int          lat, strobes, wlat;
    logic [31:0] wdat, cap_rdata;
    logic [1:0]  cap_err;
    bit          got, both;
    @(negedge clk);
    chk($sformatf("v%0d req_ready", idx), {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(posedge clk);
    #1 clear_req();
    lat = 0; strobes = 0; wlat = 0; wdat = 32'd0; got = 0; both = 0;
    cap_rdata = 32'hxxxxxxxx; cap_err = 2'bxx;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (mem_read || mem_write) strobes++;
      if (mem_read && mem_write) both = 1;
      if (mem_write) begin wlat = c; wdat = mem_din; end
      if (resp_valid) begin
        got = 1; lat = c; cap_rdata = resp_rdata; cap_err = resp_error;
      end
    end
    chk($sformatf("v%0d latency", idx), lat, v.lat);
    chk($sformatf("v%0d rdata", idx), cap_rdata, v.rdata);
    chk($sformatf("v%0d error", idx), {30'd0, cap_err}, {30'd0, v.err});
    chk($sformatf("v%0d strobes", idx), strobes, v.strobes);
    chk($sformatf("v%0d write cycle", idx), wlat, v.wlat);
    chk($sformatf("v%0d rd_and_wr", idx), {31'd0, both}, 32'd0);
    if (v.wlat != 0) chk($sformatf("v%0d write data", idx), wdat, v.wdat);
  endtask

  function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic [1:0] err, input int lat, input int strobes,
                              input int wlat, input logic [31:0] wdat);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.err = err; v.lat = lat; v.strobes = strobes; v.wlat = wlat; v.wdat = wdat;
    return v;
  endfunction

  initial begin
    vt[0]  = mk(1, 3'b010, 32'h10,    32'hDEADBEEF, 32'h0,        2'b00, 2, 1, 1, 32'hDEADBEEF);
    vt[1]  = mk(0, 3'b010, 32'h10,    32'h0,        32'hDEADBEEF, 2'b00, 2, 1, 0, 32'h0);
    vt[2]  = mk(1, 3'b010, 32'h20,    32'h8070F0AA, 32'h0,        2'b00, 2, 1, 1, 32'h8070F0AA);
    vt[3]  = mk(0, 3'b000, 32'h20,    32'h0,        32'hFFFFFFAA, 2'b00, 2, 1, 0, 32'h0);
    vt[4]  = mk(0, 3'b100, 32'h20,    32'h0,        32'h000000AA, 2'b00, 2, 1, 0, 32'h0);
    vt[5]  = mk(0, 3'b001, 32'h22,    32'h0,        32'hFFFF8070, 2'b00, 2, 1, 0, 32'h0);
    vt[6]  = mk(0, 3'b101, 32'h22,    32'h0,        32'h00008070, 2'b00, 2, 1, 0, 32'h0);
    vt[7]  = mk(0, 3'b000, 32'h23,    32'h0,        32'hFFFFFF80, 2'b00, 2, 1, 0, 32'h0);
    vt[8]  = mk(0, 3'b100, 32'h21,    32'h0,        32'h000000F0, 2'b00, 2, 1, 0, 32'h0);
    vt[9]  = mk(0, 3'b001, 32'h20,    32'h0,        32'hFFFFF0AA, 2'b00, 2, 1, 0, 32'h0);
    vt[10] = mk(0, 3'b010, 32'h13,    32'h0,        32'h0,        2'b01, 1, 0, 0, 32'h0);
    vt[11] = mk(0, 3'b001, 32'h5,     32'h0,        32'h0,        2'b01, 1, 0, 0, 32'h0);
    vt[12] = mk(0, 3'b011, 32'h10,    32'h0,        32'h0,        2'b10, 1, 0, 0, 32'h0);
    vt[13] = mk(1, 3'b010, 32'h10000, 32'h12345678, 32'h0,        2'b11, 1, 0, 0, 32'h0);
    vt[14] = mk(1, 3'b100, 32'h10,    32'h12345678, 32'h0,        2'b10, 1, 0, 0, 32'h0);
    vt[15] = mk(0, 3'b111, 32'h1,     32'h0,        32'h0,        2'b10, 1, 0, 0, 32'h0);
    vt[16] = mk(0, 3'b010, 32'h10001, 32'h0,        32'h0,        2'b01, 1, 0, 0, 32'h0);
    vt[17] = mk(0, 3'b100, 32'h10000, 32'h0,        32'h0,        2'b11, 1, 0, 0, 32'h0);
    vt[18] = mk(1, 3'b010, 32'h20,    32'h11223344, 32'h0,        2'b00, 2, 1, 1, 32'h11223344);
    vt[19] = mk(1, 3'b000, 32'h21,    32'hAAAAAA55, 32'h0,        2'b00, 3, 2, 2, 32'h11225544);
    vt[20] = mk(1, 3'b001, 32'h22,    32'h9999ABCD, 32'h0,        2'b00, 3, 2, 2, 32'hABCD5544);
    vt[21] = mk(0, 3'b010, 32'h20,    32'h0,        32'hABCD5544, 2'b00, 2, 1, 0, 32'h0);
    vt[22] = mk(1, 3'b000, 32'h23,    32'h0000007E, 32'h0,        2'b00, 3, 2, 2, 32'h7ECD5544);
    vt[23] = mk(0, 3'b000, 32'h23,    32'h0,        32'h0000007E, 2'b00, 2, 1, 0, 32'h0);
    vt[24] = mk(0, 3'b101, 32'h22,    32'h0,        32'h00007ECD, 2'b00, 2, 1, 0, 32'h0);

    clear_req();
    resp_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset req_ready",  {31'd0, req_ready},  32'd1);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset resp_rdata", resp_rdata,          32'd0);
    chk("reset resp_error", {30'd0, resp_error}, 32'd0);
    chk("reset mem_read",   {31'd0, mem_read},   32'd0);
    chk("reset mem_write",  {31'd0, mem_write},  32'd0);
    chk("reset mem_addr",   mem_addr,            32'd0);
    chk("reset mem_din",    mem_din,             32'd0);

    for (int i = 0; i < 25; i++) do_req(vt[i], i);

    // Response back-pressure: outputs must hold while resp_ready is low.
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
    @(posedge clk);
    #1 clear_req();
    @(negedge clk);
    chk("bp req_ready T+1", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("bp resp_valid T+2", {31'd0, resp_valid}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d resp_valid", c), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("bp%0d rdata", c), resp_rdata, 32'h7ECD5544);
      chk($sformatf("bp%0d error", c), {30'd0, resp_error}, 32'd0);
      chk($sformatf("bp%0d req_ready", c), {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("bp release rdata",      resp_rdata,          32'd0);
    chk("bp release req_ready",  {31'd0, req_ready},  32'd1);

    // Reset during the read half of an SH must drop the pending write.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001; req_addr = 32'h20;
    req_wdata = 32'h00001234;
    @(posedge clk);
    #1 clear_req();
    @(negedge clk);
    chk("rst rmw mem_read", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst mem_write",  {31'd0, mem_write},  32'd0);
    chk("rst req_ready",  {31'd0, req_ready},  32'd1);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst after mem_write", {31'd0, mem_write}, 32'd0);
    do_req(mk(0, 3'b010, 32'h20, 32'h0, 32'h7ECD5544, 2'b00, 2, 1, 0, 32'h0), 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
